// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with input synchronizers, wrap-around
// position count, direction flag, step strobe, and a saturating counter of
// illegal (double) phase transitions.
module quad_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 clear,
    output logic [WIDTH-1:0]     count,
    output logic                 up_down,
    output logic                 step,
    output logic                 err,
    output logic [ERR_WIDTH-1:0] err_cnt
);

    // Classification of one prev->cur comparison of the phase pair.
    typedef enum logic [1:0] {
        XFER_NONE    = 2'd0,
        XFER_FWD     = 2'd1,
        XFER_REV     = 2'd2,
        XFER_ILLEGAL = 2'd3
    } xfer_e;

    // A single synchronizer flop is not enough to tame metastability.
    if (SYNC_STAGES < 2) begin : gSyncCheck
        $error("quad_decoder: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] syncA_q;
    logic [SYNC_STAGES-1:0] syncB_q;
    logic [1:0]             cur;

    logic [1:0]             prev_q,    prev_d;
    logic [SYNC_STAGES:0]   initPipe_q, initPipe_d;
    logic                   init;
    logic [WIDTH-1:0]       count_q,   count_d;
    logic                   upDown_q,  upDown_d;
    logic                   step_q,    step_d;
    logic                   err_q,     err_d;
    logic [ERR_WIDTH-1:0]   errCnt_q,  errCnt_d;

    xfer_e                  xfer;

    // Shift each asynchronous phase pin through its own synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncA_q <= '0;
            syncB_q <= '0;
        end else begin
            syncA_q <= {syncA_q[SYNC_STAGES-2:0], enc_a};
            syncB_q <= {syncB_q[SYNC_STAGES-2:0], enc_b};
        end
    end

    assign cur = {syncA_q[SYNC_STAGES-1], syncB_q[SYNC_STAGES-1]};

    // The synchronizers come out of reset holding zeros, not the pin level,
    // so prev keeps tracking cur until the chain has carried the real pin
    // level through; only then does decoding start. This keeps whatever
    // level the encoder sits at during release from looking like a step.
    assign init = initPipe_q[0];

    // Classify the transition between the previous and current phase pair.
    always_comb begin
        xfer = XFER_NONE;
        case ({prev_q, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: xfer = XFER_FWD;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: xfer = XFER_REV;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: xfer = XFER_ILLEGAL;
            default:                                xfer = XFER_NONE;
        endcase
    end

    // Next-state: apply the decoded transition, then let clear override the
    // count and error tally (strobes still report what was decoded).
    always_comb begin
        prev_d     = cur;
        initPipe_d = initPipe_q >> 1;
        count_d    = count_q;
        upDown_d   = upDown_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        errCnt_d   = errCnt_q;

        if (!init) begin
            case (xfer)
                XFER_FWD: begin
                    count_d  = count_q + WIDTH'(1);
                    upDown_d = 1'b1;
                    step_d   = 1'b1;
                end
                XFER_REV: begin
                    count_d  = count_q - WIDTH'(1);
                    upDown_d = 1'b0;
                    step_d   = 1'b1;
                end
                XFER_ILLEGAL: begin
                    err_d = 1'b1;
                    if (errCnt_q != '1) begin
                        errCnt_d = errCnt_q + ERR_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        if (clear) begin
            count_d  = '0;
            errCnt_d = '0;
        end
    end

    // Decoder state and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= 2'b00;
            initPipe_q <= '1;
            count_q    <= '0;
            upDown_q   <= 1'b1;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            errCnt_q   <= '0;
        end else begin
            prev_q     <= prev_d;
            initPipe_q <= initPipe_d;
            count_q    <= count_d;
            upDown_q   <= upDown_d;
            step_q     <= step_d;
            err_q      <= err_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign count   = count_q;
    assign up_down = upDown_q;
    assign step    = step_q;
    assign err     = err_q;
    assign err_cnt = errCnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: directed scenarios plus a random phase walk,
// with expected strobe events queued at stimulus time and checked by an
// independent monitor whenever the DUT raises step or err.
module tb_quad_decoder;

    localparam int WIDTH     = 8;
    localparam int SYNC      = 2;
    localparam int ERRW      = 8;
    localparam int CNT_MOD   = 1 << WIDTH;
    localparam int ERR_MAX   = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            encA = 1'b1;
    logic            encB = 1'b1;
    logic            clear = 1'b0;
    logic [WIDTH-1:0] count;
    logic            upDown;
    logic            step;
    logic            err;
    logic [ERRW-1:0] errCnt;

    typedef struct {
        bit isErr;
        int count;
        bit upDown;
        int errCnt;
        int cycle;
    } exp_t;

    exp_t expQ[$];

    int vectors     = 0;
    int miscompares = 0;
    int cycleCnt    = 0;
    int stepSeen    = 0;

    int          mCount;
    bit          mUp;
    int          mErr;
    logic [1:0]  mPhase;

    quad_decoder #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC),
        .ERR_WIDTH  (ERRW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enc_a  (encA),
        .enc_b  (encB),
        .clear  (clear),
        .count  (count),
        .up_down(upDown),
        .step   (step),
        .err    (err),
        .err_cnt(errCnt)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Absolute edge counter used to time-stamp expected strobes.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Safety net so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Position of a phase pair along the forward Gray cycle 00,01,11,10.
    function automatic int phaseIdx(logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] nextFwd(logic [1:0] p);
        logic [1:0] seq [4];
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
        return seq[(phaseIdx(p) + 1) % 4];
    endfunction

    task automatic compare(string name, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic waitCycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic modelReset(logic [1:0] ph);
        mCount = 0;
        mUp    = 1'b1;
        mErr   = 0;
        mPhase = ph;
        expQ.delete();
    endtask

    // Drive a new phase pair (called just after a rising edge), update the
    // reference model and queue the strobe it should produce. With clrOnDecode
    // the clear input is raised exactly on the edge that decodes this change.
    task automatic applyStimulus(logic [1:0] ph, int hold, bit clrOnDecode);
        exp_t e;
        int   d;
        d = (phaseIdx(ph) - phaseIdx(mPhase) + 4) % 4;
        {encA, encB} = ph;
        if (d == 1) begin
            mCount = (mCount + 1) % CNT_MOD;
            mUp    = 1'b1;
        end else if (d == 3) begin
            mCount = (mCount + CNT_MOD - 1) % CNT_MOD;
            mUp    = 1'b0;
        end else if (d == 2) begin
            if (mErr < ERR_MAX) mErr++;
        end
        if (clrOnDecode) begin
            mCount = 0;
            mErr   = 0;
        end
        if (d != 0) begin
            e.isErr  = (d == 2);
            e.count  = mCount;
            e.upDown = mUp;
            e.errCnt = mErr;
            e.cycle  = cycleCnt + SYNC + 1;
            expQ.push_back(e);
        end
        mPhase = ph;
        if (clrOnDecode) begin
            waitCycles(SYNC);
            clear = 1'b1;
            waitCycles(1);
            clear = 1'b0;
        end
        waitCycles(hold);
    endtask

    task automatic checkOutput(string tag);
        compare({tag, ".count"},   32'(count),  32'(mCount));
        compare({tag, ".up_down"}, 32'(upDown), 32'(mUp));
        compare({tag, ".err_cnt"}, 32'(errCnt), 32'(mErr));
    endtask

    // Monitor: whenever the DUT raises a strobe, pop the oldest expected
    // event and compare kind, timing and the state it should leave behind.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (step || err)) begin
            if (step) stepSeen++;
            compare("strobe_exclusive", 32'(step && err), 32'd0);
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_strobe: got step=%0d err=%0d, expected none (t=%0t)",
                         step, err, $time);
            end else begin
                e = expQ.pop_front();
                compare("ev.err",     32'(err),    32'(e.isErr));
                compare("ev.step",    32'(step),   32'(!e.isErr));
                compare("ev.cycle",   32'(cycleCnt), 32'(e.cycle));
                compare("ev.count",   32'(count),  32'(e.count));
                compare("ev.up_down", 32'(upDown), 32'(e.upDown));
                compare("ev.err_cnt", 32'(errCnt), 32'(e.errCnt));
            end
        end
    end

    // Hold the phases at ph through a reset, release and settle.
    task automatic applyReset(logic [1:0] ph);
        {encA, encB} = ph;
        rst = 1'b1;
        modelReset(ph);
        waitCycles(3);
        @(negedge clk);
        rst = 1'b0;
        waitCycles(8);
    endtask

    // Main stimulus sequence.
    initial begin
        int stepBase;
        logic [1:0] upSeq [8];
        logic [1:0] rph;

        modelReset(2'b11);
        #2;
        rst = 1'b1;
        waitCycles(3);
        checkOutput("reset");
        compare("reset.step", 32'(step), 32'd0);
        compare("reset.err",  32'(err),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            waitCycles(1);
            compare("init.step", 32'(step), 32'd0);
            compare("init.err",  32'(err),  32'd0);
        end
        checkOutput("init");

        // Count up through two full encoder cycles from 00.
        applyReset(2'b00);
        upSeq[0] = 2'b01; upSeq[1] = 2'b11; upSeq[2] = 2'b10; upSeq[3] = 2'b00;
        upSeq[4] = 2'b01; upSeq[5] = 2'b11; upSeq[6] = 2'b10; upSeq[7] = 2'b00;
        stepBase = stepSeen;
        for (int i = 0; i < 8; i++) applyStimulus(upSeq[i], 4, 1'b0);
        waitCycles(4);
        checkOutput("count_up");
        compare("count_up.count_abs", 32'(count), 32'd8);
        compare("count_up.steps", 32'(stepSeen - stepBase), 32'd8);

        // Clear with no transition in flight.
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        mCount = 0;
        mErr   = 0;
        waitCycles(1);
        checkOutput("clear");

        // Down across zero, then three more.
        applyStimulus(2'b10, 4, 1'b0);
        checkOutput("wrap_down");
        compare("wrap_down.count_abs", 32'(count), 32'd255);
        applyStimulus(2'b11, 4, 1'b0);
        applyStimulus(2'b01, 4, 1'b0);
        applyStimulus(2'b00, 4, 1'b0);
        checkOutput("down3");
        compare("down3.count_abs", 32'(count), 32'd252);

        // Illegal transitions and saturation.
        applyStimulus(2'b11, 4, 1'b0);
        checkOutput("illegal1");
        compare("illegal1.err_cnt_abs", 32'(errCnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus((i % 2 == 0) ? 2'b00 : 2'b11, 1, 1'b0);
        end
        waitCycles(4);
        checkOutput("saturate");
        compare("saturate.err_cnt_abs", 32'(errCnt), 32'd255);

        // Clear colliding with a decoded forward step (11 -> 10).
        applyStimulus(2'b10, 4, 1'b1);
        checkOutput("clear_collide");
        applyStimulus(2'b00, 4, 1'b0);
        checkOutput("after_collide");
        compare("after_collide.count_abs", 32'(count), 32'd1);

        // Run up to 37 with varied hold times.
        for (int i = 0; i < 36; i++) begin
            applyStimulus(nextFwd(mPhase), $urandom_range(1, 3), 1'b0);
        end
        waitCycles(4);
        checkOutput("reach37");

        // Asynchronous reset in the middle of a clock period.
        @(negedge clk);
        #2;
        rst = 1'b1;
        {encA, encB} = 2'b10;
        modelReset(2'b10);
        #1;
        checkOutput("async_reset");
        compare("async_reset.count_abs", 32'(count), 32'd0);
        waitCycles(3);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            waitCycles(1);
            compare("rerelease.err", 32'(err), 32'd0);
        end
        applyStimulus(2'b00, 4, 1'b0);
        checkOutput("post_reset_step");
        compare("post_reset_step.count_abs", 32'(count), 32'd1);

        // Random phase walk, including holds, illegal jumps and back-to-back changes.
        for (int i = 0; i < 250; i++) begin
            rph = 2'($urandom_range(0, 3));
            applyStimulus(rph, $urandom_range(1, 5), 1'b0);
        end
        waitCycles(6);
        checkOutput("random_final");
        compare("queue_drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
